tb_and_core: RTL and testbench



---
 rtl/tb_and_pkg.sv | 14 +
 rtl/tb_and_checker.sv | 41 ++++
 rtl/tb_and_core.sv | 68 ++++++
 tb/tb_tb_and_core.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tb_and_pkg.sv
// Shared types and constants for the registered AND stage and its self-check.
// The reference function lives here so the check path stays separate from the datapath.
package tb_and_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef logic [WIDTH_DEF-1:0] operand_t;

    function automatic operand_t exp_and(input operand_t a, input operand_t b);
        return a & b;
    endfunction

endpackage

// File: rtl/tb_and_checker.sv
// Compares the registered result against the reference on every valid cycle.
// It keeps a sticky error flag and a saturating mismatch count.
module tb_and_checker
    import tb_and_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             out_valid,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] expected,
    input  logic             clr_err,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    logic             mismatch;
    logic             cnt_full;

    assign mismatch = out_valid && (c != expected);
    assign cnt_full = (err_count == {CNT_W{1'b1}});

    // clr_err wins over a mismatch in the same cycle, so that mismatch is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (clr_err) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (!cnt_full) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tb_and_core.sv
// Registered bitwise-AND stage with an independent reference path and self-check.
// The reference registers the raw operands so a datapath fault shows up as a mismatch.
module tb_and_core
    import tb_and_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_err,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic [WIDTH-1:0] expected,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c <= a & b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // The package function is fixed at the default width; other widths use a local AND
    if (WIDTH == WIDTH_DEF) begin : g_ref_pkg
        assign expected = exp_and(a_q, b_q);
    end else begin : g_ref_local
        assign expected = a_q & b_q;
    end

    tb_and_checker #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (out_valid),
        .c         (c),
        .expected  (expected),
        .clr_err   (clr_err),
        .err       (err),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_tb_and_core.sv
// Scoreboard bench for tb_and_core plus a narrow-counter checker for saturation.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the edge.
module tb_tb_and_core;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_valid;
    logic        clr_err;
    logic [7:0]  c;
    logic        out_valid;
    logic [7:0]  expected;
    logic        err;
    logic [15:0] err_count;

    logic        ck_valid;
    logic [7:0]  ck_c;
    logic [7:0]  ck_exp;
    logic        ck_clr;
    logic        ck_err;
    logic [1:0]  ck_count;

    int checks;
    int failures;
    logic [7:0] exp_q[$];

    tb_and_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .clr_err   (clr_err),
        .c         (c),
        .out_valid (out_valid),
        .expected  (expected),
        .err       (err),
        .err_count (err_count)
    );

    tb_and_checker #(
        .WIDTH(8),
        .CNT_W(2)
    ) chk2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (ck_valid),
        .c         (ck_c),
        .expected  (ck_exp),
        .clr_err   (ck_clr),
        .err       (ck_err),
        .err_count (ck_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; a = 8'hFF; b = 8'hFF; in_valid = 1'b1; clr_err = 1'b0;
        ck_valid = 1'b0; ck_c = 8'h00; ck_exp = 8'h00; ck_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (c !== 8'h00) begin failures++; $display("[TB] FAIL reset_c actual=%h required=00", c); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid); end
        checks++; if (expected !== 8'h00) begin failures++; $display("[TB] FAIL reset_expected actual=%h required=00", expected); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err actual=%b required=0", err); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_err_count actual=%0d required=0", err_count); end
        in_valid = 1'b0; a = 8'h00; b = 8'h00;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_release_valid actual=%b required=0", out_valid); end
    endtask

    task automatic test_zero_operands();
        logic [7:0] want;
        a = 8'h00; b = 8'h00; in_valid = 1'b1;
        exp_q.push_back(a & b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL zero_valid actual=%b required=1", out_valid);
        end else begin
            want = exp_q.pop_front();
            if (c !== want) begin failures++; $display("[TB] FAIL zero_c actual=%h required=%h", c, want); end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_pulse actual=%b required=0", out_valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL zero_err actual=%b required=0", err); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sa [3];
        logic [7:0] sb [3];
        logic [7:0] want;
        int produced;
        sa[0] = 8'hA5; sb[0] = 8'h0F;
        sa[1] = 8'hFF; sb[1] = 8'h3C;
        sa[2] = 8'h80; sb[2] = 8'h01;
        produced = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                a = sa[i]; b = sb[i]; in_valid = 1'b1;
                exp_q.push_back(sa[i] & sb[i]);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== (i < 3)) begin
                failures++; $display("[TB] FAIL stream_valid cycle=%0d actual=%b required=%b", i, out_valid, (i < 3));
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("[TB] FAIL stream_extra actual=%h required=none", c);
                end else begin
                    want = exp_q.pop_front();
                    produced++;
                    if (c !== want || expected !== want) begin
                        failures++; $display("[TB] FAIL stream_c actual=%h/%h required=%h", c, expected, want);
                    end
                end
            end
        end
        checks++; if (produced != 3) begin failures++; $display("[TB] FAIL stream_count actual=%0d required=3", produced); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("[TB] FAIL stream_err_count actual=%0d required=0", err_count); end
        exp_q.delete();
    endtask

    task automatic test_forced_mismatch();
        a = 8'h00; b = 8'h00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        force dut.c = 8'h01;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL mismatch_early_err actual=%b required=0", err); end
        @(posedge clk); #1;
        release dut.c;
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL mismatch_err actual=%b required=1", err); end
        checks++; if (err_count !== 16'd1) begin failures++; $display("[TB] FAIL mismatch_count actual=%0d required=1", err_count); end
        @(posedge clk); #1;
        checks++; if (err_count !== 16'd1 || err !== 1'b1) begin failures++; $display("[TB] FAIL mismatch_hold actual=%0d/%b required=1/1", err_count, err); end
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL clear_err actual=%b required=0", err); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("[TB] FAIL clear_count actual=%0d required=0", err_count); end
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        ck_valid = 1'b1; ck_c = 8'h01; ck_exp = 8'h00; ck_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            want = (i < 3) ? 2'(i + 1) : 2'd3;
            checks++;
            if (ck_count !== want) begin
                failures++; $display("[TB] FAIL sat_count step=%0d actual=%0d required=%0d", i, ck_count, want);
            end
        end
        checks++; if (ck_err !== 1'b1) begin failures++; $display("[TB] FAIL sat_err actual=%b required=1", ck_err); end
        ck_clr = 1'b1;
        @(posedge clk); #1;
        ck_clr = 1'b0;
        checks++; if (ck_count !== 2'd0 || ck_err !== 1'b0) begin failures++; $display("[TB] FAIL clr_wins actual=%0d/%b required=0/0", ck_count, ck_err); end
        ck_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (ck_count !== 2'd0) begin failures++; $display("[TB] FAIL invalid_ignored actual=%0d required=0", ck_count); end
        ck_c = 8'h00;
    endtask

    task automatic test_async_reset();
        logic [7:0] want;
        a = 8'h11; b = 8'hFF; in_valid = 1'b1;
        exp_q.push_back(a & b);
        @(posedge clk); #1;
        a = 8'h22; b = 8'hF0;
        exp_q.push_back(a & b);
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL async_first_valid actual=%b required=1", out_valid);
        end else begin
            want = exp_q.pop_front();
            if (c !== want) begin failures++; $display("[TB] FAIL async_first_c actual=%h required=%h", c, want); end
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (c !== 8'h00 || out_valid !== 1'b0 || expected !== 8'h00 || err !== 1'b0 || err_count !== 16'd0) begin
            failures++; $display("[TB] FAIL async_clear actual=%h/%b/%h/%b/%0d required=00/0/00/0/0", c, out_valid, expected, err, err_count);
        end
        @(posedge clk); #1;
        checks++; if (c !== 8'h00) begin failures++; $display("[TB] FAIL async_hold_c actual=%h required=00", c); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_release_valid actual=%b required=0", out_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_zero_operands();
        test_back_to_back();
        test_forced_mismatch();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
